frame_buffer_responder: RTL

Memory-side responder for the single-port pixel-stage bus (address/wren/data_write out, data_read/pause in) driven by processing stages such as the pixel-filling passes. It serves each client transaction from a one-entry read cache or from a slow, handshaked external frame-buffer memory. It stretches the client's timing by asserting pause until the data is ready. The stage sees exactly the 1-cycle read behaviour it expects from block RAM.

---
 rtl/fb_bus_pkg.sv | 7 +
 rtl/fb_read_cache.sv | 39 +++
 rtl/frame_buffer_responder.sv | 76 +++++++
 3 files changed

// File: rtl/fb_bus_pkg.sv
// fb_bus_pkg: shared widths, frame size and responder FSM states for the pixel-stage bus
package fb_bus_pkg;
    localparam int FB_ADDR_W = 18;
    localparam int FB_DATA_W = 32;
    localparam int FRAME_WORDS = 76800;
    typedef enum logic [1:0] {ACCEPT, ACCESS, RESPOND} fb_state_t;
endpackage

// File: rtl/fb_read_cache.sv
// fb_read_cache: one-entry read cache with hit compare, fill, timeout clear and flush
module fb_read_cache #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              flush,
    input  logic              update,
    input  logic [ADDR_W-1:0] update_addr,
    input  logic [DATA_W-1:0] update_data,
    input  logic              clear,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic              valid;
    logic [ADDR_W-1:0] addr;

    assign hit = valid && addr == lookup_addr && !flush;

    // a fresh fill beats a coincident flush; an aborted access leaves the entry empty and zeroed
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (update) begin
            valid <= 1'b1;
            addr  <= update_addr;
            data  <= update_data;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/frame_buffer_responder.sv
// frame_buffer_responder: serves pixel-stage bus transactions from a one-entry cache or slow external memory
module frame_buffer_responder
    import fb_bus_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_div_by_two,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              wren,
    input  logic [DATA_W-1:0] data_write,
    output logic [DATA_W-1:0] data_read,
    output logic              pause,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              timeout_error
);
    fb_state_t state, state_next;
    logic [7:0] cnt;
    logic       hit, read_hit, start, ack_ok, tmo;

    fb_read_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cache (
        .clk(clk_div_by_two),
        .reset(reset),
        .lookup_addr(address),
        .flush(flush),
        .update(ack_ok),
        .update_addr(mem_addr),
        .update_data(mem_we ? mem_wdata : mem_rdata),
        .clear(tmo),
        .hit(hit),
        .data(data_read)
    );

    assign mem_req = state == ACCESS;

    // next state and client hold; acks outside ACCESS never qualify
    always_comb begin
        read_hit   = state == ACCEPT && !wren && hit;
        start      = state == ACCEPT && !read_hit;
        ack_ok     = state == ACCESS && mem_ack;
        tmo        = state == ACCESS && !mem_ack && cnt >= 8'(TIMEOUT_CYCLES - 1);
        pause      = state == ACCESS || start;
        state_next = start ? ACCESS : (ack_ok || tmo) ? RESPOND : state == RESPOND ? ACCEPT : state;
    end

    // state register, latched memory request, saturating wait counter and sticky timeout flag
    always_ff @(posedge clk_div_by_two) begin
        if (reset) begin
            state         <= ACCEPT;
            cnt           <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            timeout_error <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                cnt       <= '0;
                mem_we    <= wren;
                mem_addr  <= address;
                mem_wdata <= data_write;
            end else if (state == ACCESS && cnt != 8'(TIMEOUT_CYCLES)) begin
                cnt <= cnt + 8'd1;
            end
            if (tmo) timeout_error <= 1'b1;
        end
    end
endmodule
